// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// default iteration count and small operand helpers.
package mips_pkg;

    localparam int ITER_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } md_state_t;

    // Divides are the upper half of the op encoding.
    function automatic logic op_is_div(input md_op_t op);
        return op[1];
    endfunction

    // MULT and DIV are signed; the U variants have bit 0 set.
    function automatic logic op_is_signed(input md_op_t op);
        return ~op[0];
    endfunction

    // Absolute value for signed ops. 0x8000_0000 maps to itself, which read
    // as unsigned is exactly 2^31, so the 64-bit path never overflows.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Pipeline-to-muldiv bus: EX-stage issue, HI/LO moves and the unit's status.
interface muldiv_ctrl_if;

    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        rd_hilo;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    // Pipeline side.
    modport master (
        output start, op, rs_data, rt_data, mthi, mtlo, wdata, rd_hilo, flush,
        input  busy, stall, done, hi, lo
    );

    // Multiply/divide unit side.
    modport slave (
        input  start, op, rs_data, rt_data, mthi, mtlo, wdata, rd_hilo, flush,
        output busy, stall, done, hi, lo
    );

endinterface

// File: rtl/muldiv_dp.sv
// Combinational datapath: one shift-add / restoring shift-subtract step on the
// 64-bit working register, plus final sign correction of the result.
module muldiv_dp
    import mips_pkg::*;
(
    input  md_op_t      op,
    input  logic [63:0] work,      // multiply: {acc, multiplier}; divide: {rem, quotient}
    input  logic [31:0] opnd,      // multiplicand or divisor magnitude
    input  logic        neg_res,   // operand signs differed on a signed op
    input  logic        neg_rem,   // dividend was negative on a signed divide
    input  logic        div_zero,  // work already holds the divide-by-zero result
    output logic [63:0] step,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic [32:0] sum;
    logic [32:0] part;
    logic [31:0] diff;
    logic [63:0] prod;

    // One iteration of the multiply or divide recurrence.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the branches leaves it unassigned and infers a latch.
        step = work;
        sum  = '0;
        part = '0;
        diff = '0;
        if (op_is_div(op)) begin
            // Shift the remainder left; the bit leaving work[63] is kept as part[32].
            part = work[63:31];
            diff = part[31:0] - opnd;
            if (part >= {1'b0, opnd}) begin
                step = {diff, work[30:0], 1'b1};
            end else begin
                step = {work[62:0], 1'b0};
            end
        end else begin
            // Add the multiplicand when the current multiplier bit is set, then shift right.
            sum  = {1'b0, work[63:32]} + (work[0] ? {1'b0, opnd} : 33'd0);
            step = {sum, work[31:1]};
        end
    end

    // Sign correction applied to the finished magnitude result.
    always_comb begin
        prod   = neg_res ? -work : work;
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (div_zero) begin
            res_hi = work[63:32];
            res_lo = work[31:0];
        end else if (op_is_div(op)) begin
            res_lo = neg_res ? -work[31:0]  : work[31:0];
            res_hi = neg_rem ? -work[63:32] : work[63:32];
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide unit: FSM, iteration counter, HI/LO registers and
// the pipeline handshake. The arithmetic step lives in muldiv_dp.
module muldiv_ctrl
    import mips_pkg::*;
#(
    parameter int ITER = ITER_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_ctrl_if.slave bus
);

    localparam int                CNT_W    = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ITER - 1);

    md_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic             done_q;

    md_op_t           op_q;
    logic [63:0]      work;
    logic [31:0]      opnd;
    logic             neg_res;
    logic             neg_rem;
    logic             div_zero;

    md_op_t           op_in;
    logic             in_signed;
    logic             rt_zero;
    logic             accept;
    logic             busy;

    logic [63:0]      step;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;

    assign op_in     = md_op_t'(bus.op);
    assign in_signed = op_is_signed(op_in);
    assign rt_zero   = op_is_div(op_in) && (bus.rt_data == 32'd0);
    // A flush in IDLE kills the instruction presenting start.
    assign accept    = (state == ST_IDLE) && bus.start && !bus.flush;

    // Control FSM, iteration counter, HI/LO and the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the pre-edge values, as the hardware does.
            done_q <= 1'b0;
            if (bus.flush) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            // start wins over a simultaneous MTHI/MTLO.
                            cnt   <= '0;
                            state <= rt_zero ? ST_FIX : ST_CALC;
                        end else begin
                            if (bus.mthi) hi_q <= bus.wdata;
                            if (bus.mtlo) lo_q <= bus.wdata;
                        end
                    end
                    ST_CALC: begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_LAST) state <= ST_FIX;
                    end
                    ST_FIX: begin
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Operand latch and working register; reloaded on every accepted start.
    always_ff @(posedge clk) begin
        // NOTE: no reset here on purpose: these are only read after an
        // accepted start has loaded them, so reset would only cost routing.
        if (accept) begin
            op_q     <= op_in;
            neg_res  <= in_signed & (bus.rs_data[31] ^ bus.rt_data[31]);
            neg_rem  <= in_signed & bus.rs_data[31];
            div_zero <= rt_zero;
            if (rt_zero) begin
                work <= {bus.rs_data, 32'hFFFF_FFFF};
                opnd <= bus.rt_data;
            end else if (op_is_div(op_in)) begin
                work <= {32'd0, magnitude(bus.rs_data, in_signed)};
                opnd <= magnitude(bus.rt_data, in_signed);
            end else begin
                work <= {32'd0, magnitude(bus.rt_data, in_signed)};
                opnd <= magnitude(bus.rs_data, in_signed);
            end
        end else if (state == ST_CALC) begin
            work <= step;
        end
    end

    muldiv_dp u_dp (
        .op       (op_q),
        .work     (work),
        .opnd     (opnd),
        .neg_res  (neg_res),
        .neg_rem  (neg_rem),
        .div_zero (div_zero),
        .step     (step),
        .res_hi   (res_hi),
        .res_lo   (res_lo)
    );

    assign busy      = (state != ST_IDLE);
    assign bus.busy  = busy;
    assign bus.stall = busy & (bus.start | bus.rd_hilo | bus.mthi | bus.mtlo);
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter ITER, default 32, meaning number of iteration cycles per multiply/divide.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  EX-stage multiply/divide issue strobe.
REQ-005 SHALL have port op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port rs_data  input  32  multiplicand/dividend.
REQ-007 SHALL have port rt_data  input  32  multiplier/divisor.
REQ-008 SHALL have port mthi  input  1  write wdata to HI.
REQ-009 SHALL have port mtlo  input  1  write wdata to LO.
REQ-010 SHALL have port wdata  input  32  MTHI/MTLO data.
REQ-011 SHALL have port rd_hilo  input  1  EX stage holds MFHI/MFLO.
REQ-012 SHALL have port flush  input  1  pipeline flush; abort in-flight operation.
REQ-013 SHALL have port busy  output  1  operation in flight.
REQ-014 SHALL have port stall  output  1  freeze IF/ID/EX.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port hi  output  32  HI register.
REQ-017 SHALL have port lo  output  32  LO register.

Function
REQ-018 SHALL implement states IDLE, CALC, FIX; busy = (state != IDLE).
REQ-019 SHALL, in IDLE with start=1 and flush=0, latch op and operand magnitudes (signed ops: absolute value; unsigned: raw), clear iteration counter, enter CALC at the next edge.
REQ-020 SHALL, in CALC, perform one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, on a 64-bit working register, for exactly ITER cycles, then enter FIX.
REQ-021 SHALL, in FIX, apply sign correction (signed ops only): product negated if operand signs differ; quotient negated if signs differ; remainder takes dividend sign.
REQ-022 SHALL, at the edge leaving FIX, write HI (product[63:32] or remainder) and LO (product[31:0] or quotient), return to IDLE, and assert done for exactly the following cycle.
REQ-023 SHALL therefore assert done in the (ITER+2)th cycle after the start edge (34 cycles at default).
REQ-024 SHALL, on divide with rt_data=0, skip CALC (IDLE -> FIX), write HI=rs_data, LO=32'hFFFF_FFFF, done 2 cycles after start.
REQ-025 SHALL treat signed 32'h8000_0000 magnitude as unsigned 2^31 (no overflow in the 64-bit path); DIV 0x80000000 / -1 SHALL yield LO=32'h8000_0000, HI=0.
REQ-026 SHALL drive stall = busy & (start | rd_hilo | mthi | mtlo); stall SHALL be 0 in IDLE.
REQ-027 SHALL ignore start, mthi, mtlo while busy (pipeline is stalled and re-presents them).
REQ-028 SHALL, in IDLE, apply mthi/mtlo at the next edge; if start and mthi/mtlo are simultaneous, start SHALL win and mthi/mtlo SHALL be dropped.
REQ-029 SHALL, on flush in any state, return to IDLE at the next edge, leave HI/LO unchanged, and not assert done; flush in IDLE SHALL suppress a simultaneous start.
REQ-030 SHALL keep hi/lo stable except at REQ-022, REQ-024, REQ-028 write edges.

Reset
REQ-031 SHALL, on rst=1, asynchronously force state=IDLE, counter=0, hi=0, lo=0, done=0, busy=0, stall=0.
REQ-032 SHALL, on rst mid-operation, discard the operation; first start after rst deassertion SHALL behave as REQ-019.

Structure
REQ-033 SHALL take op encodings, state enumeration and ITER default from shared package mips_pkg.
REQ-034 SHALL split the 64-bit shift-add/shift-subtract step and sign correction into sub-module muldiv_dp; muldiv_ctrl holds FSM, counter, HI/LO and handshake.

Verification
REQ-035 SHALL test MULT rs=-3 (32'hFFFF_FFFD), rt=7 -> done at cycle 34, HI=32'hFFFF_FFFF, LO=32'hFFFF_FFEB.
REQ-036 SHALL test MULTU rs=rt=32'hFFFF_FFFF -> HI=32'hFFFF_FFFE, LO=32'h0000_0001.
REQ-037 SHALL test DIV rs=-7, rt=2 -> LO=32'hFFFF_FFFD (-3), HI=32'hFFFF_FFFF (-1); DIVU rs=7, rt=0 -> done at cycle 2, HI=7, LO=32'hFFFF_FFFF.
REQ-038 SHALL test rd_hilo asserted cycle 5 after start -> stall=1 until done cycle, then 0; MFLO sees new LO.
REQ-039 SHALL test flush at cycle 10 of a MULT after mtlo wrote 32'h1234 -> IDLE next cycle, no done, LO=32'h1234.
REQ-040 SHALL test rst pulse at cycle 20 of a DIV -> hi=lo=0, busy=0 immediately; subsequent MULTU 3x5 -> LO=15, HI=0.
